// File: rtl/conj_demod_pkg.sv
// ---------------------------------------------------------------------------
// conj_demod_pkg
//   Shared definitions for the lagged conjugate-product discriminator.
//   - PIPE_LAT  : accepted-sample to output-valid latency in clocks.
//   - iq_t      : complex sample at the nominal 16-bit chain width.
//   - sat_round : round-half-up arithmetic right shift followed by
//                 saturation to a signed out_w-bit range.
// ---------------------------------------------------------------------------
package conj_demod_pkg;

   localparam int PIPE_LAT = 3;
   localparam int IQ_DEF_W = 16;

   typedef struct packed {
      logic signed [IQ_DEF_W-1:0] im;
      logic signed [IQ_DEF_W-1:0] re;
   } iq_t;

   // v is a sign-extended full-precision sum; shift in 1..62, out_w in 2..63.
   // The result fits in out_w bits and is returned sign-extended to 64 bits.
   function automatic logic signed [63:0] sat_round(
      input logic signed [63:0] v,
      input int                 shift,
      input int                 out_w
   );
      logic signed [63:0] t;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      t  = (v + (64'sd1 <<< (shift - 1))) >>> shift;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (t > hi) begin
         sat_round = hi;
      end else if (t < lo) begin
         sat_round = lo;
      end else begin
         sat_round = t;
      end
   endfunction

endpackage

// File: rtl/iq_history.sv
// ---------------------------------------------------------------------------
// iq_history
//   DEPTH-deep sample delay line. Each push shifts i_data in at the young end;
//   o_oldest is the entry pushed DEPTH pushes ago.
//   Ports:
//     i_clk    : clock
//     i_push   : shift enable (one sample accepted)
//     i_data   : sample to store
//     o_oldest : oldest stored sample
//   Contents are deliberately not reset: the caller masks them until DEPTH
//   samples have been pushed since the last reset or packet boundary.
// ---------------------------------------------------------------------------
module iq_history
   import conj_demod_pkg::*;
#(
   parameter int W     = 32,
   parameter int DEPTH = 1
) (
   input  logic         i_clk,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_oldest
);

   logic [W-1:0] r_mem [DEPTH];

   // Delay line shift on every accepted sample.
   always_ff @(posedge i_clk) begin
      if (i_push) begin
         r_mem[0] <= i_data;
         for (int k = 1; k < DEPTH; k++) begin
            r_mem[k] <= r_mem[k-1];
         end
      end
   end

   assign o_oldest = r_mem[DEPTH-1];

endmodule

// File: rtl/conj_demod_lag.sv
// ---------------------------------------------------------------------------
// conj_demod_lag
//   Lagged conjugate-product FM discriminator on a complex AXI-Stream:
//      y[n] = x[n] * conj(x[n-LAG]), rounded (half up), shifted by SHIFT and
//      saturated to OUT_W bits per component.
//   Three register stages (operands, products, scaled sum), one sample per
//   clock, full backpressure. Output is {0,0} until LAG samples have been
//   accepted since reset or (RESET_ON_LAST) since the last accepted tlast.
//   Ports:
//     s00_axis_aclk / s00_axis_areset : clock, async active-high reset
//     s00_axis_t*  : input stream, tdata = {imag, real}
//     m00_axis_t*  : output stream, tdata = {imag, real}, tstrb all ones
// ---------------------------------------------------------------------------
module conj_demod_lag
   import conj_demod_pkg::*;
#(
   parameter int IQ_W                   = 16,
   parameter int OUT_W                  = 16,
   parameter int LAG                    = 1,
   parameter int SHIFT                  = 16,
   parameter int RESET_ON_LAST          = 1,
   parameter int C_S00_AXIS_TDATA_WIDTH = 2*IQ_W,
   parameter int C_M00_AXIS_TDATA_WIDTH = 2*OUT_W
) (
   input  logic                                s00_axis_aclk,
   input  logic                                s00_axis_areset,
   input  logic                                s00_axis_tvalid,
   output logic                                s00_axis_tready,
   input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
   input  logic                                s00_axis_tlast,
   input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
   output logic                                m00_axis_tvalid,
   input  logic                                m00_axis_tready,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
   output logic                                m00_axis_tlast,
   output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb
);

   localparam int              CNT_W   = $clog2(LAG + 1);
   localparam logic [CNT_W-1:0] LAG_CNT = CNT_W'(LAG);
   localparam int              SUM_W   = 2*IQ_W + 1;

   // Handshake
   logic w_en;
   logic w_accept;
   logic w_primed;
   logic w_unused_tstrb;

   // Priming
   logic [CNT_W-1:0] r_prime_cnt;

   // History
   logic [2*IQ_W-1:0] w_hist;

   // Stage 1: operands
   logic              r_s1_vld;
   logic              r_s1_last;
   logic [2*IQ_W-1:0] r_cur;
   logic [2*IQ_W-1:0] r_prev;
   logic signed [IQ_W-1:0] w_a;
   logic signed [IQ_W-1:0] w_b;
   logic signed [IQ_W-1:0] w_c;
   logic signed [IQ_W-1:0] w_d;

   // Stage 2: products
   logic                     r_s2_vld;
   logic                     r_s2_last;
   logic signed [2*IQ_W-1:0] r_ac;
   logic signed [2*IQ_W-1:0] r_bd;
   logic signed [2*IQ_W-1:0] r_bc;
   logic signed [2*IQ_W-1:0] r_ad;

   // Stage 3: sums and scaling
   logic signed [SUM_W-1:0] w_re_sum;
   logic signed [SUM_W-1:0] w_im_sum;
   logic signed [OUT_W-1:0] w_sat_re;
   logic signed [OUT_W-1:0] w_sat_im;

   // The whole pipe moves as one unit; a stalled output freezes everything.
   assign w_en            = !m00_axis_tvalid || m00_axis_tready;
   assign s00_axis_tready = w_en;
   assign w_accept        = s00_axis_tvalid && w_en;
   assign w_primed        = (r_prime_cnt == LAG_CNT);

   // Every beat carries a full I/Q pair, so input strobes carry no information.
   assign w_unused_tstrb = ^s00_axis_tstrb;

   iq_history #(
      .W     (2*IQ_W),
      .DEPTH (LAG)
   ) u_hist (
      .i_clk    (s00_axis_aclk),
      .i_push   (w_accept),
      .i_data   (s00_axis_tdata[2*IQ_W-1:0]),
      .o_oldest (w_hist)
   );

   // x = a + jb (current), p = c + jd (lagged); x*conj(p) = (ac+bd) + j(bc-ad)
   assign w_a = r_cur[IQ_W-1:0];
   assign w_b = r_cur[2*IQ_W-1:IQ_W];
   assign w_c = r_prev[IQ_W-1:0];
   assign w_d = r_prev[2*IQ_W-1:IQ_W];

   assign w_re_sum = SUM_W'(r_ac) + SUM_W'(r_bd);
   assign w_im_sum = SUM_W'(r_bc) - SUM_W'(r_ad);
   assign w_sat_re = OUT_W'(sat_round(64'(w_re_sum), SHIFT, OUT_W));
   assign w_sat_im = OUT_W'(sat_round(64'(w_im_sum), SHIFT, OUT_W));

   // Priming counter: counts accepted samples up to LAG; an accepted tlast
   // restarts priming for the sample after it.
   always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
      if (s00_axis_areset) begin
         r_prime_cnt <= '0;
      end else if (w_accept) begin
         if ((RESET_ON_LAST != 0) && s00_axis_tlast) begin
            r_prime_cnt <= '0;
         end else if (!w_primed) begin
            r_prime_cnt <= r_prime_cnt + CNT_W'(1);
         end
      end
   end

   // Three-stage datapath with registered AXI-Stream outputs.
   always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
      if (s00_axis_areset) begin
         r_s1_vld        <= 1'b0;
         r_s1_last       <= 1'b0;
         r_cur           <= '0;
         r_prev          <= '0;
         r_s2_vld        <= 1'b0;
         r_s2_last       <= 1'b0;
         r_ac            <= '0;
         r_bd            <= '0;
         r_bc            <= '0;
         r_ad            <= '0;
         m00_axis_tvalid <= 1'b0;
         m00_axis_tdata  <= '0;
         m00_axis_tlast  <= 1'b0;
         m00_axis_tstrb  <= '0;
      end else begin
         m00_axis_tstrb <= '1;
         if (w_en) begin
            // Stage 1: a bubble clears the valid bit but leaves operands as-is
            r_s1_vld  <= s00_axis_tvalid;
            r_s1_last <= w_accept & s00_axis_tlast;
            if (w_accept) begin
               r_cur  <= s00_axis_tdata[2*IQ_W-1:0];
               r_prev <= w_primed ? w_hist : '0;
            end
            // Stage 2
            r_s2_vld  <= r_s1_vld;
            r_s2_last <= r_s1_last;
            r_ac      <= (2*IQ_W)'(w_a) * (2*IQ_W)'(w_c);
            r_bd      <= (2*IQ_W)'(w_b) * (2*IQ_W)'(w_d);
            r_bc      <= (2*IQ_W)'(w_b) * (2*IQ_W)'(w_c);
            r_ad      <= (2*IQ_W)'(w_a) * (2*IQ_W)'(w_d);
            // Stage 3
            m00_axis_tvalid <= r_s2_vld;
            m00_axis_tlast  <= r_s2_last;
            m00_axis_tdata  <= {w_sat_im, w_sat_re};
         end
      end
   end

endmodule

// File: tb/tb_conj_demod_lag.sv
// ---------------------------------------------------------------------------
// tb_conj_demod_lag
//   Two instances driven by the same stream: A (LAG=1) and B (LAG=4), both
//   re-priming on tlast. A packet-level model predicts every output beat.
// ---------------------------------------------------------------------------
module tb_conj_demod_lag;
   import conj_demod_pkg::*;

   typedef struct {
      int re;
      int im;
      bit last;
   } beat_t;

   logic        clk;
   logic        rst;
   logic        s_tvalid;
   logic        s_tlast;
   logic [31:0] s_tdata;
   logic [3:0]  s_tstrb;
   logic        m_tready;

   logic        a_s_tready, a_m_tvalid, a_m_tlast;
   logic [31:0] a_m_tdata;
   logic [3:0]  a_m_tstrb;
   logic        b_s_tready, b_m_tvalid, b_m_tlast;
   logic [31:0] b_m_tdata;
   logic [3:0]  b_m_tstrb;

   conj_demod_lag #(.LAG(1), .RESET_ON_LAST(1)) dut_a (
      .s00_axis_aclk   (clk),
      .s00_axis_areset (rst),
      .s00_axis_tvalid (s_tvalid),
      .s00_axis_tready (a_s_tready),
      .s00_axis_tdata  (s_tdata),
      .s00_axis_tlast  (s_tlast),
      .s00_axis_tstrb  (s_tstrb),
      .m00_axis_tvalid (a_m_tvalid),
      .m00_axis_tready (m_tready),
      .m00_axis_tdata  (a_m_tdata),
      .m00_axis_tlast  (a_m_tlast),
      .m00_axis_tstrb  (a_m_tstrb)
   );

   conj_demod_lag #(.LAG(4), .RESET_ON_LAST(1)) dut_b (
      .s00_axis_aclk   (clk),
      .s00_axis_areset (rst),
      .s00_axis_tvalid (s_tvalid),
      .s00_axis_tready (b_s_tready),
      .s00_axis_tdata  (s_tdata),
      .s00_axis_tlast  (s_tlast),
      .s00_axis_tstrb  (s_tstrb),
      .m00_axis_tvalid (b_m_tvalid),
      .m00_axis_tready (m_tready),
      .m00_axis_tdata  (b_m_tdata),
      .m00_axis_tlast  (b_m_tlast),
      .m00_axis_tstrb  (b_m_tstrb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    n_vec = 0;
   int    n_err = 0;
   int    stall_cycles = 0;
   beat_t exp_a[$], exp_b[$], log_a[$], log_b[$];
   iq_t   pkt_a[$], pkt_b[$];
   bit    stall_a = 1'b0, stall_b = 1'b0;
   logic [31:0] hold_a, hold_b;
   logic        hold_la, hold_lb;

   function automatic void chk(string name, longint act, longint exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Round half up by floor division, then clamp to 16-bit signed.
   function automatic int sr(longint v);
      longint t;
      longint q;
      t = v + 64'sd32768;
      q = t / 64'sd65536;
      if ((t % 64'sd65536) != 0 && t < 0) q = q - 64'sd1;
      if (q > 64'sd32767) q = 64'sd32767;
      if (q < -64'sd32768) q = -64'sd32768;
      return int'(q);
   endfunction

   function automatic beat_t conj_y(iq_t x, iq_t p, bit last);
      longint a, b, c, d;
      beat_t  r;
      a = x.re; b = x.im; c = p.re; d = p.im;
      r.re = sr(a*c + b*d);
      r.im = sr(b*c - a*d);
      r.last = last;
      return r;
   endfunction

   // Newest sample of the packet against the one LAG places earlier; zero
   // while the packet is shorter than LAG+1 samples.
   function automatic beat_t y_of(input iq_t pkt[$], input int lag, input bit last);
      int  n;
      iq_t z;
      z = '0;
      n = pkt.size() - 1;
      if (n >= lag) return conj_y(pkt[n], pkt[n-lag], last);
      return conj_y(pkt[n], z, last);
   endfunction

   function automatic beat_t dec(logic [31:0] d, logic l);
      beat_t r;
      r.re = int'($signed(d[15:0]));
      r.im = int'($signed(d[31:16]));
      r.last = l;
      return r;
   endfunction

   function automatic void cmp(string tag, beat_t e, beat_t g, logic [3:0] strb);
      chk({tag, ".re"},   g.re, e.re);
      chk({tag, ".im"},   g.im, e.im);
      chk({tag, ".last"}, g.last, e.last);
      chk({tag, ".strb"}, strb, 15);
   endfunction

   function automatic void lit(string tag, beat_t g, int re, int im);
      chk({tag, ".re"}, g.re, re);
      chk({tag, ".im"}, g.im, im);
   endfunction

   // Compare process: mid-cycle, checks handshake rule, stall stability,
   // consumed beats against the model, and feeds accepted samples to it.
   always @(negedge clk) begin
      beat_t g;
      iq_t   x;
      if (rst) begin
         exp_a.delete(); exp_b.delete(); pkt_a.delete(); pkt_b.delete();
         stall_a = 1'b0; stall_b = 1'b0;
      end else begin
         chk("a.tready_rule", a_s_tready, !a_m_tvalid || m_tready);
         chk("b.tready_rule", b_s_tready, !b_m_tvalid || m_tready);
         if (stall_a) begin
            chk("a.hold_valid", a_m_tvalid, 1);
            chk("a.hold_data", a_m_tdata, hold_a);
            chk("a.hold_last", a_m_tlast, hold_la);
         end
         if (stall_b) begin
            chk("b.hold_valid", b_m_tvalid, 1);
            chk("b.hold_data", b_m_tdata, hold_b);
            chk("b.hold_last", b_m_tlast, hold_lb);
         end
         stall_a = a_m_tvalid && !m_tready;
         stall_b = b_m_tvalid && !m_tready;
         hold_a = a_m_tdata; hold_la = a_m_tlast;
         hold_b = b_m_tdata; hold_lb = b_m_tlast;
         if (stall_a) stall_cycles++;
         if (a_m_tvalid && m_tready) begin
            g = dec(a_m_tdata, a_m_tlast);
            log_a.push_back(g);
            if (exp_a.size() == 0) chk("a.extra_beat", 1, 0);
            else cmp("a.beat", exp_a.pop_front(), g, a_m_tstrb);
         end
         if (b_m_tvalid && m_tready) begin
            g = dec(b_m_tdata, b_m_tlast);
            log_b.push_back(g);
            if (exp_b.size() == 0) chk("b.extra_beat", 1, 0);
            else cmp("b.beat", exp_b.pop_front(), g, b_m_tstrb);
         end
         if (s_tvalid && a_s_tready) begin
            x = iq_t'(s_tdata);
            pkt_a.push_back(x);
            exp_a.push_back(y_of(pkt_a, 1, s_tlast));
            if (s_tlast) pkt_a.delete();
            pkt_b.push_back(x);
            exp_b.push_back(y_of(pkt_b, 4, s_tlast));
            if (s_tlast) pkt_b.delete();
         end
      end
   end

   // Offer one sample from posedge+1 until accepted; returns at posedge+1.
   task automatic send(int re, int im, bit last);
      bit ok;
      s_tdata  = {16'(im), 16'(re)};
      s_tlast  = last;
      s_tstrb  = 4'hF;
      s_tvalid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk);
         ok = a_s_tready;
         @(posedge clk);
         #1;
      end
      if (!ok) chk("send_timeout", 0, 1);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 60 && (exp_a.size() != 0 || exp_b.size() != 0); k++) begin
         @(posedge clk);
         #1;
      end
      chk("drain.a", exp_a.size(), 0);
      chk("drain.b", exp_b.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int k;
      rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 32'h0;
      s_tstrb = 4'h0; m_tready = 1'b1;
      #3;
      chk("rst.tvalid", a_m_tvalid, 0);
      chk("rst.tdata",  a_m_tdata, 0);
      chk("rst.tlast",  a_m_tlast, 0);
      chk("rst.tstrb",  a_m_tstrb, 0);
      chk("rst.b_tvalid", b_m_tvalid, 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;

      // Priming and latency, LAG=1
      base = log_a.size();
      send(16384, 0, 1'b0);
      k = 1;
      while (!a_m_tvalid && k < 10) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("latency", k, PIPE_LAT);
      send(0, 16384, 1'b1);
      drain();
      lit("prime.y0", log_a[base],   0, 0);
      lit("prime.y1", log_a[base+1], 0, 4096);

      // Saturation
      base = log_a.size();
      send(-32768, -32768, 1'b0);
      send(-32768, -32768, 1'b1);
      drain();
      lit("sat.y0", log_a[base],   0, 0);
      lit("sat.y1", log_a[base+1], 32767, 0);

      // Rounding, each pair its own packet
      base = log_a.size();
      send(181, 0, 1'b0);
      send(181, 0, 1'b1);
      send(256, 0, 1'b0);
      send(256, 0, 1'b1);
      drain();
      lit("round.181", log_a[base+1], 0, 0);
      lit("round.256", log_a[base+3], 1, 0);

      // Backpressure: 10 samples, downstream stalled for 5 cycles
      base = log_a.size();
      stall_cycles = 0;
      fork
         begin
            for (int i = 0; i < 10; i++) send(1000*i - 3000, 700 - 300*i, i == 9);
         end
         begin
            repeat (4) @(posedge clk);
            #1 m_tready = 1'b0;
            repeat (5) @(posedge clk);
            #1 m_tready = 1'b1;
         end
      join
      drain();
      chk("bp.count", log_a.size() - base, 10);
      chk("bp.stalled", stall_cycles > 0, 1);

      // LAG=4 with re-priming on tlast
      base = log_b.size();
      for (int i = 0; i < 6; i++) send(256*(i+1), -128*i, i == 5);
      for (int i = 0; i < 6; i++) send(300*(i+1), 200*i - 500, i == 5);
      drain();
      for (int i = 0; i < 4; i++) begin
         lit("lag4.p1_prime", log_b[base+i],   0, 0);
         lit("lag4.p2_prime", log_b[base+6+i], 0, 0);
      end
      lit("lag4.y4", log_b[base+4], 5, -2);
      lit("lag4.y5", log_b[base+5], 13, -2);
      chk("lag4.last4", log_b[base+4].last, 0);
      chk("lag4.last5", log_b[base+5].last, 1);
      chk("lag4.last6", log_b[base+6].last, 0);

      // Async reset with three samples in flight
      send(1000, 1000, 1'b0);
      send(2000, -500, 1'b0);
      send(3000, 700, 1'b0);
      send(-1500, 400, 1'b0);
      chk("rst.pre_valid", a_m_tvalid, 1);
      #1 rst = 1'b1;
      #1;
      chk("rst.async_a", a_m_tvalid, 0);
      chk("rst.async_b", b_m_tvalid, 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      base = log_a.size();
      send(100, 50, 1'b0);
      send(200, -30, 1'b1);
      drain();
      chk("rst.count", log_a.size() - base, 2);
      lit("rst.first_a", log_a[base], 0, 0);
      lit("rst.first_b", log_b[log_b.size()-2], 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
